// File: rtl/controle_contador_pkg.sv
// Shared codes for the 0..8 cyclic counter controller: UD mode codes,
// FSM state encoding and the counter value limits.
package controle_contador_pkg;

  localparam logic [1:0] UD_HOLD = 2'b00;
  localparam logic [1:0] UD_DOWN = 2'b01;
  localparam logic [1:0] UD_UP   = 2'b10;
  localparam logic [1:0] UD_ERR  = 2'b11;

  localparam logic [3:0] CNT_MAX = 4'd8;
  localparam logic [3:0] CNT_ERR = 4'd9;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    SUBINDO  = 2'd1,
    DESCENDO = 2'd2,
    ERRO     = 2'd3
  } modo_e;

  typedef struct packed {
    logic up;
    logic down;
    logic stop;
    logic err;
  } req_t;

  function automatic logic [1:0] ud_of(input modo_e m);
    case (m)
      SUBINDO:  return UD_UP;
      DESCENDO: return UD_DOWN;
      ERRO:     return UD_ERR;
      default:  return UD_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/controle_contador_prox_estado.sv
// Combinational step function: next counter value for a mode code.
// Out-of-range values (10..15) behave exactly like the error code.
module prox_estado
  import controle_contador_pkg::*;
#(
  parameter logic [3:0] MAX = CNT_MAX,
  parameter logic [3:0] ERR = CNT_ERR
) (
  input  logic [1:0] ud_i,
  input  logic [3:0] atual_i,
  output logic [3:0] prox_o
);

  logic valido;
  assign valido = (atual_i <= MAX);

  always_comb begin
    prox_o = atual_i;
    case (ud_i)
      UD_UP:   prox_o = (valido && atual_i != MAX) ? atual_i + 4'd1 : 4'd0;
      UD_DOWN: prox_o = (valido && atual_i != 4'd0) ? atual_i - 4'd1 : MAX;
      UD_ERR:  prox_o = ERR;
      default: prox_o = atual_i;
    endcase
  end

endmodule

// File: rtl/controle_contador.sv
// Mode sequencer and counter owner: edge-detects operator requests, runs the
// PARADO/SUBINDO/DESCENDO/ERRO FSM and paces count steps with a prescaler.
module controle_contador
  import controle_contador_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter logic [3:0]  MAX = CNT_MAX,
  parameter logic [3:0]  ERR = CNT_ERR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_up,
  input  logic       req_down,
  input  logic       req_stop,
  input  logic       req_err,
  output logic [1:0] ud,
  output logic [3:0] atual,
  output logic [1:0] modo,
  output logic       passo
);

  localparam int unsigned     PW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PLAST = PW'(DIV - 1);

  req_t          req_now, req_hist_q, rise;
  modo_e         modo_q, modo_d;
  logic [1:0]    ud_q, ud_sel;
  logic [3:0]    atual_q, atual_d, prox;
  logic [PW-1:0] presc_q, presc_d;
  logic          passo_q, passo_d;
  logic          load, tick, so_up, so_down, correndo;

  assign req_now = '{up: req_up, down: req_down, stop: req_stop, err: req_err};

  assign rise.up   = req_now.up   & ~req_hist_q.up;
  assign rise.down = req_now.down & ~req_hist_q.down;
  assign rise.stop = req_now.stop & ~req_hist_q.stop;
  assign rise.err  = req_now.err  & ~req_hist_q.err;

  // Simultaneous up and down rises cancel each other.
  assign so_up   = rise.up & ~rise.down;
  assign so_down = rise.down & ~rise.up;

  assign correndo = (modo_q == SUBINDO) || (modo_q == DESCENDO);
  assign tick     = correndo && (presc_q == PLAST);

  prox_estado #(.MAX(MAX), .ERR(ERR)) u_prox (
    .ud_i    (ud_sel),
    .atual_i (atual_q),
    .prox_o  (prox)
  );

  // Any accepted request leaves presc_d at its default of 0, so mode changes
  // and direction re-requests restart the step pacing.
  always_comb begin
    modo_d  = modo_q;
    presc_d = '0;
    passo_d = 1'b0;
    load    = 1'b0;
    ud_sel  = ud_q;
    case (modo_q)
      PARADO: begin
        if      (rise.err)  modo_d = ERRO;
        else if (rise.stop) modo_d = PARADO;
        else if (so_up)     modo_d = SUBINDO;
        else if (so_down)   modo_d = DESCENDO;
      end
      SUBINDO, DESCENDO: begin
        if      (rise.err)  modo_d = ERRO;
        else if (rise.stop) modo_d = PARADO;
        else if (so_up)     modo_d = SUBINDO;
        else if (so_down)   modo_d = DESCENDO;
        else if (tick) begin
          load    = 1'b1;
          passo_d = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ERRO: begin
        if (rise.stop) modo_d = PARADO;
      end
      default: modo_d = PARADO;
    endcase
    if (modo_d == ERRO && modo_q != ERRO) begin
      load   = 1'b1;
      ud_sel = UD_ERR;
    end
  end

  assign atual_d = load ? prox : atual_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_hist_q <= '1;
      modo_q     <= PARADO;
      ud_q       <= UD_HOLD;
      atual_q    <= 4'd0;
      presc_q    <= '0;
      passo_q    <= 1'b0;
    end else begin
      req_hist_q <= req_now;
      modo_q     <= modo_d;
      ud_q       <= ud_of(modo_d);
      atual_q    <= atual_d;
      presc_q    <= presc_d;
      passo_q    <= passo_d;
    end
  end

  assign ud    = ud_q;
  assign atual = atual_q;
  assign modo  = modo_q;
  assign passo = passo_q;

endmodule

// File: tb/tb_controle_contador.sv
// Scoreboard bench for controle_contador (DIV=4): per-cycle expectations of
// {atual, modo, ud, passo} are queued with the stimulus and checked after each edge.
module tb_controle_contador;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_up, req_down, req_stop, req_err;
  logic [1:0] ud, modo;
  logic [3:0] atual;
  logic       passo;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] stim[$];

  controle_contador #(.DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_up   (req_up),
    .req_down (req_down),
    .req_stop (req_stop),
    .req_err  (req_err),
    .ud       (ud),
    .atual    (atual),
    .modo     (modo),
    .passo    (passo)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pk(input logic [3:0] a, input logic [1:0] m,
                                    input logic [1:0] u, input logic p);
    return {a, m, u, p};
  endfunction

  // Queue one cycle: request pattern {up,down,stop,err} and the state expected after the edge.
  task automatic cyc(input logic [3:0] r, input logic [8:0] v, input string n);
    exp_t e;
    e.v = v;
    e.name = n;
    stim.push_back(r);
    sb.push_back(e);
  endtask

  task automatic waitn(input int n, input logic [8:0] v, input string nm);
    for (int i = 0; i < n; i++) cyc(4'b0000, v, nm);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    {req_up, req_down, req_stop, req_err} = 4'b0000;
    repeat (2) clk_edge();
    e = '{v: pk(4'd0, 2'd0, 2'b00, 1'b0), name: "rst_vals"};
    vectors++;
    if ({atual, modo, ud, passo} !== e.v) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
    end
    req_up = 1'b1;
    clk_edge();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(4'b1000, pk(4'd0, 2'd0, 2'b00, 1'b0), "rst_up_held");
    cyc(4'b0000, pk(4'd0, 2'd0, 2'b00, 1'b0), "rst_up_fall");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  task automatic test_up();
    exp_t e;
    logic [3:0] seq [9];
    logic [3:0] prev;
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0};
    prev = 4'd0;
    cyc(4'b1000, pk(4'd0, 2'd1, 2'b10, 1'b0), "up_enter");
    for (int i = 0; i < 9; i++) begin
      waitn(3, pk(prev, 2'd1, 2'b10, 1'b0), "up_wait");
      cyc(4'b0000, pk(seq[i], 2'd1, 2'b10, 1'b1), "up_step");
      prev = seq[i];
    end
    cyc(4'b0010, pk(4'd0, 2'd0, 2'b00, 1'b0), "up_stop");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  task automatic test_down();
    exp_t e;
    cyc(4'b0100, pk(4'd0, 2'd2, 2'b01, 1'b0), "down_enter");
    waitn(3, pk(4'd0, 2'd2, 2'b01, 1'b0), "down_wait0");
    cyc(4'b0000, pk(4'd8, 2'd2, 2'b01, 1'b1), "down_0_to_max");
    waitn(3, pk(4'd8, 2'd2, 2'b01, 1'b0), "down_wait8");
    cyc(4'b0000, pk(4'd7, 2'd2, 2'b01, 1'b1), "down_8_to_7");
    cyc(4'b0010, pk(4'd7, 2'd0, 2'b00, 1'b0), "down_stop");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  task automatic test_err();
    exp_t e;
    cyc(4'b0100, pk(4'd7, 2'd2, 2'b01, 1'b0), "err_pre_down");
    waitn(3, pk(4'd7, 2'd2, 2'b01, 1'b0), "err_pre_w7");
    cyc(4'b0000, pk(4'd6, 2'd2, 2'b01, 1'b1), "err_pre_6");
    waitn(3, pk(4'd6, 2'd2, 2'b01, 1'b0), "err_pre_w6");
    cyc(4'b0000, pk(4'd5, 2'd2, 2'b01, 1'b1), "err_pre_5");
    cyc(4'b1000, pk(4'd5, 2'd1, 2'b10, 1'b0), "err_redir_up");
    waitn(2, pk(4'd5, 2'd1, 2'b10, 1'b0), "err_sub_5");
    cyc(4'b0001, pk(4'd9, 2'd3, 2'b11, 1'b0), "err_enter");
    cyc(4'b1000, pk(4'd9, 2'd3, 2'b11, 1'b0), "err_up_ign");
    waitn(4, pk(4'd9, 2'd3, 2'b11, 1'b0), "err_hold");
    cyc(4'b0100, pk(4'd9, 2'd3, 2'b11, 1'b0), "err_down_ign");
    cyc(4'b0010, pk(4'd9, 2'd0, 2'b00, 1'b0), "err_leave");
    waitn(2, pk(4'd9, 2'd0, 2'b00, 1'b0), "err_parado_9");
    cyc(4'b1000, pk(4'd9, 2'd1, 2'b10, 1'b0), "err_up_again");
    waitn(3, pk(4'd9, 2'd1, 2'b10, 1'b0), "err_up_wait");
    cyc(4'b0000, pk(4'd0, 2'd1, 2'b10, 1'b1), "err_9_to_0");
    cyc(4'b0010, pk(4'd0, 2'd0, 2'b00, 1'b0), "err_final_stop");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  task automatic test_same_cycle();
    exp_t e;
    cyc(4'b1100, pk(4'd0, 2'd0, 2'b00, 1'b0), "sc_up_down");
    waitn(2, pk(4'd0, 2'd0, 2'b00, 1'b0), "sc_still_parado");
    cyc(4'b1001, pk(4'd9, 2'd3, 2'b11, 1'b0), "sc_err_up");
    cyc(4'b0000, pk(4'd9, 2'd3, 2'b11, 1'b0), "sc_err_hold");
    cyc(4'b0010, pk(4'd9, 2'd0, 2'b00, 1'b0), "sc_leave");
    cyc(4'b0100, pk(4'd9, 2'd2, 2'b01, 1'b0), "sc_down_from9");
    waitn(3, pk(4'd9, 2'd2, 2'b01, 1'b0), "sc_down_wait");
    cyc(4'b0000, pk(4'd8, 2'd2, 2'b01, 1'b1), "sc_9_to_max");
    cyc(4'b1000, pk(4'd8, 2'd1, 2'b10, 1'b0), "sc_redir_up");
    waitn(3, pk(4'd8, 2'd1, 2'b10, 1'b0), "sc_up_wait8");
    cyc(4'b0000, pk(4'd0, 2'd1, 2'b10, 1'b1), "sc_8_to_0");
    waitn(3, pk(4'd0, 2'd1, 2'b10, 1'b0), "sc_up_wait0");
    cyc(4'b0000, pk(4'd1, 2'd1, 2'b10, 1'b1), "sc_0_to_1");
    cyc(4'b0000, pk(4'd1, 2'd1, 2'b10, 1'b0), "sc_up_wait1");
    cyc(4'b0110, pk(4'd1, 2'd0, 2'b00, 1'b0), "sc_stop_down");
    waitn(5, pk(4'd1, 2'd0, 2'b00, 1'b0), "sc_parado_hold");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  // Ends in SUBINDO with atual=6 and the prescaler at 2.
  task automatic test_restart();
    exp_t e;
    logic [3:0] seq [4];
    logic [3:0] prev;
    seq = '{4'd3, 4'd4, 4'd5, 4'd6};
    cyc(4'b1000, pk(4'd1, 2'd1, 2'b10, 1'b0), "rr_enter");
    waitn(2, pk(4'd1, 2'd1, 2'b10, 1'b0), "rr_wait_a");
    cyc(4'b1000, pk(4'd1, 2'd1, 2'b10, 1'b0), "rr_rereq");
    waitn(3, pk(4'd1, 2'd1, 2'b10, 1'b0), "rr_no_early_step");
    cyc(4'b0000, pk(4'd2, 2'd1, 2'b10, 1'b1), "rr_step");
    prev = 4'd2;
    for (int i = 0; i < 4; i++) begin
      waitn(3, pk(prev, 2'd1, 2'b10, 1'b0), "rr_wait");
      cyc(4'b0000, pk(seq[i], 2'd1, 2'b10, 1'b1), "rr_climb");
      prev = seq[i];
    end
    waitn(2, pk(4'd6, 2'd1, 2'b10, 1'b0), "rr_mid_6");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    #3;
    rst = 1'b1;
    #1;
    e = '{v: pk(4'd0, 2'd0, 2'b00, 1'b0), name: "rst_async"};
    vectors++;
    if ({atual, modo, ud, passo} !== e.v) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
    end
    clk_edge();
    rst = 1'b0;
    waitn(4, pk(4'd0, 2'd0, 2'b00, 1'b0), "rst_idle");
    cyc(4'b1000, pk(4'd0, 2'd1, 2'b10, 1'b0), "rst_new_up");
    waitn(3, pk(4'd0, 2'd1, 2'b10, 1'b0), "rst_new_wait");
    cyc(4'b0000, pk(4'd1, 2'd1, 2'b10, 1'b1), "rst_new_step");
    while (stim.size() > 0) begin
      {req_up, req_down, req_stop, req_err} = stim.pop_front();
      clk_edge();
      e = sb.pop_front();
      vectors++;
      if ({atual, modo, ud, passo} !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", e.name, {atual, modo, ud, passo}, e.v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_up();
    test_down();
    test_err();
    test_same_cycle();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/controle_contador.md
Name: controle_contador

Overview:
Sequencer and owner of the 0–8 cyclic counter state register with its code-9 error state. Turns four operator request lines (up, down, stop, error) into a mode FSM and drives the 2-bit UD mode code (00 hold, 01 down, 10 up, 11 force-9). Contains a prescaler that paces count steps. Sits between the debounced front-panel buttons and the display decoder.

Parameters:
DIV, 4, clk cycles per count step (DIV >= 1; DIV=1 gives a step every cycle)
MAX, 8, highest valid count value
ERR, 9, error/blank code

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_up  in  1  level request: count up
req_down  in  1  level request: count down
req_stop  in  1  level request: hold / leave error
req_err  in  1  level request: force error state
ud  out  2  current mode code (00 hold, 01 down, 10 up, 11 force-9)
atual  out  4  registered count value, 0..MAX or ERR
modo  out  2  FSM state (0 PARADO, 1 SUBINDO, 2 DESCENDO, 3 ERRO)
passo  out  1  one-cycle pulse on every clk edge where atual is updated by a step

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: atual=0, modo=PARADO, ud=00, passo=0, prescaler=0, all request-history flops=1.
- Because history resets to 1, a request held high through reset generates no edge.
- Edge detection: rise_x = req_x & ~req_x_d, where req_x_d is req_x registered.
- A rise present before clk edge k updates modo/ud at edge k. Latency is one cycle from request high to new mode.
- Arbitration of rises in the same cycle: err > stop > {up, down}.
- up and down rising together, with no err or stop rise, are both ignored; the mode is unchanged.
- FSM transitions:
  - PARADO: up→SUBINDO, down→DESCENDO, err→ERRO, stop→PARADO (no change).
  - SUBINDO/DESCENDO: up→SUBINDO, down→DESCENDO, stop→PARADO, err→ERRO. Re-requesting the current direction restarts the prescaler.
  - ERRO: only a stop rise exits, to PARADO. Up and down rises are ignored.
- ud is a direct function of the registered modo: PARADO=00, DESCENDO=01, SUBINDO=10, ERRO=11.
- Prescaler: counts 0..DIV-1 only while in SUBINDO or DESCENDO. tick = (prescaler==DIV-1).
  - Prescaler clears to 0 on every accepted mode change or direction re-request.
  - First step therefore occurs DIV cycles after the mode edge.
  - Prescaler is held at 0 in PARADO and ERRO.
- Step on tick (the prescaler wraps to 0 on that cycle):
  - up: atual 0..MAX-1 → +1; MAX or ERR → 0.
  - down: atual 1..MAX → −1; 0 or ERR → MAX.
  - passo=1 on the same edge that atual updates; 0 otherwise.
- Entering ERRO sets atual=ERR at the same edge modo becomes ERRO. No tick wait; passo=0 on that edge.
- Leaving ERRO to PARADO keeps atual=ERR. A later up gives 0 and a later down gives MAX, each after DIV cycles.
- PARADO holds atual and passo=0.
- Arithmetic is 4-bit unsigned. Values 10–15 cannot occur; if forced, treat them as ERR for the step rules.
- Reset mid-step: all outputs return to reset values immediately, independent of clk.

Decomposition:
- Shared package: mode codes UD_HOLD=2'b00, UD_DOWN=2'b01, UD_UP=2'b10, UD_ERR=2'b11; state encodings PARADO/SUBINDO/DESCENDO/ERRO; constants MAX=8 and ERR=9.
- One natural sub-module, prox_estado: a combinational next-value function (ud, atual) → prox implementing the step rules above.
- The controller registers prox_estado's output only on tick or on error entry.

Test Plan:
- Reset with all req=0 → atual=0, ud=00, modo=0, passo=0. Hold req_up high across reset release → no mode change.
- DIV=4, PARADO at 0, pulse req_up → ud=10 next cycle. passo every 4th clk; atual goes 1,2,…,8,0 (wrap after 9 steps).
- From PARADO at 0, pulse req_down → after 4 clk atual=8, after 8 clk atual=7, ud=01.
- While SUBINDO at 5, pulse req_err → next edge modo=3, ud=11, atual=9.
  - req_up pulse is then ignored.
  - req_stop pulse → modo=0, atual=9.
  - req_up → atual=0 after 4 clk.
- Same-cycle rises: up+down from PARADO → stays PARADO. err+up → ERRO. stop+down while SUBINDO → PARADO, atual unchanged.
- Assert rst mid-count (atual=6, prescaler=2) between clk edges → atual=0, modo=0, passo=0 immediately. Counting restarts only after a new req_up rise.
